// File: rtl/window_discriminator_fsm.sv
// rtl/window_discriminator_fsm.sv - multi-window spike discriminator FSM for one amplifier channel
//
// Purpose: a trigger crossing on window 0 starts an event. Every later valid
// sample is checked against NUM_WIN gated amplitude thresholds, and the event
// is decided at offset stop_max. detect_o pulses for one clock when every
// enabled inclusion window was hit and no enabled exclusion window was hit.
// The configuration is captured at the trigger, so it can change during an
// event without affecting that event.
//
// Ports:
//   dataclk_i         system clock, rising edge
//   reset_i           asynchronous active-high reset
//   enable_i          0 aborts any event and forces IDLE
//   sample_valid_i    qualifies sample_in_i
//   sample_in_i       offset-binary sample, compared unsigned
//   thrsh_flat_i      threshold k at [k*DATA_W +: DATA_W]
//   thrsh_pol_i       1: hit if sample >= thr, 0: hit if sample <= thr
//   edge_type_i       0 inclusion, 1 exclusion (bit 0 forced inclusion)
//   win_en_i          per-window enable, bit 0 gates the trigger
//   win_start_flat_i  first offset of window k, inclusive
//   win_stop_flat_i   last offset of window k, inclusive
//   stop_max_i        offset at which the event is decided
//   holdoff_i         valid samples ignored after a decision
//   detect_o          one-cycle pass pulse
//   busy_o            high in TRACK, DECIDE and HOLDOFF
//   win_hit_o         sticky per-window hit flags of current/last event
//   fsm_state_o       0 IDLE, 1 TRACK, 2 DECIDE, 3 HOLDOFF
//   sample_cnt_o      offset of the last accepted sample
`timescale 1ns/1ps
module window_discriminator_fsm #(
  parameter int NUM_WIN = 4,
  parameter int DATA_W  = 16,
  parameter int CNT_W   = 8
) (
  input  logic                       dataclk_i,
  input  logic                       reset_i,
  input  logic                       enable_i,
  input  logic                       sample_valid_i,
  input  logic [DATA_W-1:0]          sample_in_i,
  input  logic [NUM_WIN*DATA_W-1:0]  thrsh_flat_i,
  input  logic [NUM_WIN-1:0]         thrsh_pol_i,
  input  logic [NUM_WIN-1:0]         edge_type_i,
  input  logic [NUM_WIN-1:0]         win_en_i,
  input  logic [NUM_WIN*CNT_W-1:0]   win_start_flat_i,
  input  logic [NUM_WIN*CNT_W-1:0]   win_stop_flat_i,
  input  logic [CNT_W-1:0]           stop_max_i,
  input  logic [CNT_W-1:0]           holdoff_i,
  output logic                       detect_o,
  output logic                       busy_o,
  output logic [NUM_WIN-1:0]         win_hit_o,
  output logic [1:0]                 fsm_state_o,
  output logic [CNT_W-1:0]           sample_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TRACK   = 2'd1,
    S_DECIDE  = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  state_t                      state_q;
  logic                        detect_q;
  logic [NUM_WIN-1:0]          win_hit_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [CNT_W-1:0]            hold_cnt_q;

  // Configuration snapshot taken at the trigger
  logic [NUM_WIN*DATA_W-1:0]   thr_q;
  logic [NUM_WIN-1:0]          pol_q;
  logic [NUM_WIN-1:0]          edge_q;
  logic [NUM_WIN-1:0]          en_q;
  logic [NUM_WIN*CNT_W-1:0]    start_q;
  logic [NUM_WIN*CNT_W-1:0]    stop_q;
  logic [CNT_W-1:0]            stop_max_q;
  logic [CNT_W-1:0]            holdoff_q;

  // In IDLE the trigger sample is judged against the live inputs, since the
  // snapshot is only being loaded on that same edge.
  logic                        in_idle;
  logic [NUM_WIN*DATA_W-1:0]   eff_thr;
  logic [NUM_WIN-1:0]          eff_pol;
  logic [NUM_WIN-1:0]          eff_edge;
  logic [NUM_WIN-1:0]          eff_en;
  logic [NUM_WIN*CNT_W-1:0]    eff_start;
  logic [NUM_WIN*CNT_W-1:0]    eff_stop;
  logic [CNT_W-1:0]            eval_cnt;
  logic [NUM_WIN-1:0]          samp_hit;
  logic [NUM_WIN-1:0]          win_eval;
  logic [NUM_WIN-1:0]          hit_d;
  logic                        pass_d;
  logic                        trigger;

  assign in_idle   = (state_q == S_IDLE);
  assign eff_thr   = in_idle ? thrsh_flat_i     : thr_q;
  assign eff_pol   = in_idle ? thrsh_pol_i      : pol_q;
  assign eff_edge  = (in_idle ? edge_type_i     : edge_q) & ~NUM_WIN'(1);
  assign eff_en    = in_idle ? win_en_i         : en_q;
  assign eff_start = in_idle ? win_start_flat_i : start_q;
  assign eff_stop  = in_idle ? win_stop_flat_i  : stop_q;
  assign eval_cnt  = in_idle ? '0 : cnt_q + CNT_W'(1);

  always_comb begin
    samp_hit = '0;
    win_eval = '0;
    for (int k = 0; k < NUM_WIN; k++) begin
      samp_hit[k] = eff_pol[k] ? (sample_in_i >= eff_thr[k*DATA_W +: DATA_W])
                               : (sample_in_i <= eff_thr[k*DATA_W +: DATA_W]);
      // start > stop leaves an empty range, so the window can never hit
      win_eval[k] = eff_en[k] && samp_hit[k] &&
                    (eff_start[k*CNT_W +: CNT_W] <= eval_cnt) &&
                    (eval_cnt <= eff_stop[k*CNT_W +: CNT_W]);
    end
  end

  // The trigger restarts the flags; during tracking they are sticky
  assign hit_d   = in_idle ? win_eval : (win_hit_q | win_eval);
  // Inclusion is satisfied by a hit, exclusion by its absence
  assign pass_d  = &(~eff_en | (hit_d ^ eff_edge));
  assign trigger = sample_valid_i && enable_i && win_en_i[0] && samp_hit[0];

  always_ff @(posedge dataclk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      detect_q   <= 1'b0;
      win_hit_q  <= '0;
      cnt_q      <= '0;
      hold_cnt_q <= '0;
      thr_q      <= '0;
      pol_q      <= '0;
      edge_q     <= '0;
      en_q       <= '0;
      start_q    <= '0;
      stop_q     <= '0;
      stop_max_q <= '0;
      holdoff_q  <= '0;
    end else begin
      detect_q <= 1'b0;
      if (!enable_i) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (trigger) begin
              thr_q      <= thrsh_flat_i;
              pol_q      <= thrsh_pol_i;
              edge_q     <= edge_type_i;
              en_q       <= win_en_i;
              start_q    <= win_start_flat_i;
              stop_q     <= win_stop_flat_i;
              stop_max_q <= stop_max_i;
              holdoff_q  <= holdoff_i;
              cnt_q      <= '0;
              win_hit_q  <= hit_d;
              if (stop_max_i == '0) begin
                state_q  <= S_DECIDE;
                detect_q <= pass_d;
              end else begin
                state_q  <= S_TRACK;
              end
            end
          end
          S_TRACK: begin
            if (sample_valid_i) begin
              cnt_q     <= eval_cnt;
              win_hit_q <= hit_d;
              if (eval_cnt == stop_max_q) begin
                state_q  <= S_DECIDE;
                detect_q <= pass_d;
              end
            end
          end
          S_DECIDE: begin
            hold_cnt_q <= '0;
            state_q    <= (holdoff_q != '0) ? S_HOLDOFF : S_IDLE;
          end
          S_HOLDOFF: begin
            if (sample_valid_i) begin
              if (hold_cnt_q + CNT_W'(1) == holdoff_q) begin
                state_q <= S_IDLE;
              end else begin
                hold_cnt_q <= hold_cnt_q + CNT_W'(1);
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign detect_o     = detect_q;
  assign busy_o       = (state_q != S_IDLE);
  assign win_hit_o    = win_hit_q;
  assign fsm_state_o  = state_q;
  assign sample_cnt_o = cnt_q;

endmodule

// File: tb/tb_window_discriminator_fsm.sv
// tb/tb_window_discriminator_fsm.sv - directed vector bench for window_discriminator_fsm
`timescale 1ns/1ps
module tb_window_discriminator_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        valid;
  logic [15:0] sample;
  logic [63:0] thr_flat;
  logic [3:0]  pol;
  logic [3:0]  edge_t;
  logic [3:0]  en;
  logic [31:0] start_flat;
  logic [31:0] stop_flat;
  logic [7:0]  stop_max;
  logic [7:0]  holdoff;
  logic        detect;
  logic        busy;
  logic [3:0]  win_hit;
  logic [1:0]  fsm_state;
  logic [7:0]  sample_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  window_discriminator_fsm #(.NUM_WIN(4), .DATA_W(16), .CNT_W(8)) dut (
    .dataclk_i        (clk),
    .reset_i          (rst),
    .enable_i         (enable),
    .sample_valid_i   (valid),
    .sample_in_i      (sample),
    .thrsh_flat_i     (thr_flat),
    .thrsh_pol_i      (pol),
    .edge_type_i      (edge_t),
    .win_en_i         (en),
    .win_start_flat_i (start_flat),
    .win_stop_flat_i  (stop_flat),
    .stop_max_i       (stop_max),
    .holdoff_i        (holdoff),
    .detect_o         (detect),
    .busy_o           (busy),
    .win_hit_o        (win_hit),
    .fsm_state_o      (fsm_state),
    .sample_cnt_o     (sample_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] s;
    logic        det;
    logic        bsy;
    logic [3:0]  hit;
    logic [1:0]  st;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[32];
  int   n_rows;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_row(input logic v, input logic [15:0] s, input logic det, input logic bsy,
                         input logic [3:0] hit, input logic [1:0] st, input logic [7:0] cnt);
    tbl[n_rows] = '{v, s, det, bsy, hit, st, cnt};
    n_rows++;
  endtask

  task automatic set_base();
    thr_flat   = {16'd0, 16'd0, 16'd0, 16'd32532};
    pol        = 4'b0000;
    edge_t     = 4'b1110;
    en         = 4'b1111;
    start_flat = {8'd0, 8'd0, 8'd0, 8'd0};
    stop_flat  = {8'd9, 8'd9, 8'd9, 8'd1};
    stop_max   = 8'd9;
    holdoff    = 8'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One valid sample preceded by an idle clock; returns #1 after its edge
  task automatic send(input logic [15:0] s);
    repeat (2) @(negedge clk);
    valid  = 1'b1;
    sample = s;
    @(posedge clk);
    #1;
    valid  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Trigger plus offsets 1..9, with dip_val placed at dip_off
  task automatic run_event(input logic [15:0] dip_val, input int dip_off);
    send(16'd32500);
    for (int off = 1; off <= 9; off++)
      send((off == dip_off) ? dip_val : 16'd32768);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < n_rows; i++) begin
      @(negedge clk);
      valid  = tbl[i].v;
      sample = tbl[i].s;
      @(posedge clk);
      #1;
      chk($sformatf("%s row%0d detect", tag, i), {31'd0, detect}, {31'd0, tbl[i].det});
      chk($sformatf("%s row%0d busy", tag, i), {31'd0, busy}, {31'd0, tbl[i].bsy});
      chk($sformatf("%s row%0d win_hit", tag, i), {28'd0, win_hit}, {28'd0, tbl[i].hit});
      chk($sformatf("%s row%0d state", tag, i), {30'd0, fsm_state}, {30'd0, tbl[i].st});
      chk($sformatf("%s row%0d cnt", tag, i), {24'd0, sample_cnt}, {24'd0, tbl[i].cnt});
    end
    valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    valid  = 1'b0;
    sample = 16'd32768;
    set_base();

    // Scenario 1 trace: quiet channel, exclusion windows 1..3 stay clear
    n_rows = 0;
    add_row(0, 16'd32768, 0, 0, 4'b0000, 2'd0, 8'd0);
    add_row(1, 16'd32768, 0, 0, 4'b0000, 2'd0, 8'd0);
    add_row(0, 16'd32768, 0, 0, 4'b0000, 2'd0, 8'd0);
    add_row(1, 16'd32500, 0, 1, 4'b0001, 2'd1, 8'd0);
    add_row(0, 16'd32768, 0, 1, 4'b0001, 2'd1, 8'd0);
    for (int i = 1; i <= 8; i++) begin
      add_row(1, 16'd32768, 0, 1, 4'b0001, 2'd1, 8'(i));
      add_row(0, 16'd32768, 0, 1, 4'b0001, 2'd1, 8'(i));
    end
    add_row(1, 16'd32768, 1, 1, 4'b0001, 2'd2, 8'd9);
    add_row(0, 16'd32768, 0, 0, 4'b0001, 2'd0, 8'd9);
    add_row(0, 16'd32768, 0, 0, 4'b0001, 2'd0, 8'd9);

    #12;
    chk("reset detect", {31'd0, detect}, 32'd0);
    chk("reset state", {30'd0, fsm_state}, 32'd0);
    chk("reset win_hit", {28'd0, win_hit}, 32'd0);
    rst = 1'b0;
    run_table("s1");

    // Scenario 2: inclusion window 1 must see a dip inside [1,7]
    do_reset();
    set_base();
    thr_flat[31:16]  = 16'd32430;
    edge_t           = 4'b0000;
    en               = 4'b0011;
    start_flat[15:8] = 8'd1;
    stop_flat[15:8]  = 8'd7;
    run_event(16'd32400, 3);
    chk("s2 dip@3 detect", {31'd0, detect}, 32'd1);
    chk("s2 dip@3 win_hit", {28'd0, win_hit}, 32'd3);
    chk("s2 dip@3 cnt", {24'd0, sample_cnt}, 32'd9);
    run_event(16'd32400, 8);
    chk("s2 dip@8 detect", {31'd0, detect}, 32'd0);
    chk("s2 dip@8 win_hit", {28'd0, win_hit}, 32'd1);
    chk("s2 dip@8 state", {30'd0, fsm_state}, 32'd2);

    // Scenario 3: exclusion window 2 is violated by a spike at offset 6
    do_reset();
    set_base();
    en                = 4'b0101;
    edge_t            = 4'b0100;
    pol               = 4'b0100;
    thr_flat[47:32]   = 16'd32968;
    start_flat[23:16] = 8'd5;
    stop_flat[23:16]  = 8'd8;
    run_event(16'd33000, 6);
    chk("s3 spike detect", {31'd0, detect}, 32'd0);
    chk("s3 spike win_hit", {28'd0, win_hit}, 32'd5);
    run_event(16'd32768, 0);
    chk("s3 quiet detect", {31'd0, detect}, 32'd1);
    chk("s3 quiet win_hit", {28'd0, win_hit}, 32'd1);

    // Scenario 4: decide on the trigger itself, then hold off 3 samples
    do_reset();
    set_base();
    stop_max = 8'd0;
    holdoff  = 8'd3;
    send(16'd32500);
    chk("s4 trig detect", {31'd0, detect}, 32'd1);
    chk("s4 trig state", {30'd0, fsm_state}, 32'd2);
    tick();
    chk("s4 holdoff state", {30'd0, fsm_state}, 32'd3);
    chk("s4 holdoff detect", {31'd0, detect}, 32'd0);
    chk("s4 holdoff busy", {31'd0, busy}, 32'd1);
    send(16'd32500);
    chk("s4 ign1 state", {30'd0, fsm_state}, 32'd3);
    send(16'd32500);
    chk("s4 ign2 state", {30'd0, fsm_state}, 32'd3);
    send(16'd32500);
    chk("s4 ign3 state", {30'd0, fsm_state}, 32'd0);
    chk("s4 ign3 detect", {31'd0, detect}, 32'd0);
    send(16'd32500);
    chk("s4 retrig detect", {31'd0, detect}, 32'd1);
    chk("s4 retrig state", {30'd0, fsm_state}, 32'd2);

    // Scenario 5: abort on enable drop, and snapshot protection of thr1
    do_reset();
    set_base();
    thr_flat[31:16]  = 16'd32430;
    edge_t           = 4'b0000;
    en               = 4'b0011;
    start_flat[15:8] = 8'd1;
    stop_flat[15:8]  = 8'd7;
    send(16'd32500);
    for (int off = 1; off <= 4; off++) send(16'd32768);
    chk("s5 pre-abort cnt", {24'd0, sample_cnt}, 32'd4);
    @(negedge clk);
    enable = 1'b0;
    tick();
    chk("s5 abort state", {30'd0, fsm_state}, 32'd0);
    chk("s5 abort detect", {31'd0, detect}, 32'd0);
    chk("s5 abort win_hit", {28'd0, win_hit}, 32'd1);
    enable = 1'b1;
    for (int off = 5; off <= 9; off++) send(16'd32768);
    chk("s5 no late detect", {31'd0, detect}, 32'd0);
    chk("s5 stays idle", {30'd0, fsm_state}, 32'd0);
    send(16'd32500);
    send(16'd32768);
    send(16'd32768);
    thr_flat[31:16] = 16'd0;
    for (int off = 3; off <= 9; off++) send((off == 3) ? 16'd32400 : 16'd32768);
    chk("s5 snapshot detect", {31'd0, detect}, 32'd1);
    chk("s5 snapshot win_hit", {28'd0, win_hit}, 32'd3);

    // Scenario 6: asynchronous reset mid-event, then a clean scenario-1 run
    do_reset();
    set_base();
    send(16'd32500);
    for (int off = 1; off <= 5; off++) send(16'd32768);
    chk("s6 pre-reset state", {30'd0, fsm_state}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("s6 async state", {30'd0, fsm_state}, 32'd0);
    chk("s6 async busy", {31'd0, busy}, 32'd0);
    chk("s6 async win_hit", {28'd0, win_hit}, 32'd0);
    chk("s6 async cnt", {24'd0, sample_cnt}, 32'd0);
    chk("s6 async detect", {31'd0, detect}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_table("s6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
